// File: rtl/apb_controller_if.sv
// Request/response and APB bus bundle between the AHB slave side, the sequencer and the APB slaves.
// Purely structural: no storage, no added latency.
// Backpressure is carried by hreadyout; APB2 has no wait states, so there is no pready.
interface apb_controller_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // AHB-side request
  logic          valid;
  logic [AW-1:0] haddr;
  logic [DW-1:0] hwdata;
  logic          hwrite;
  // AHB-side response
  logic          hreadyout;
  logic [DW-1:0] hrdata;
  logic          rvalid;
  logic          herror;
  // APB bus
  logic [DW-1:0] prdata;
  logic [2:0]    pselx;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;

  // Sequencer side
  modport slave (
    input  valid, haddr, hwdata, hwrite, prdata,
    output hreadyout, hrdata, rvalid, herror,
    output pselx, penable, pwrite, paddr, pwdata
  );

  // Requester / APB slave model side
  modport master (
    output valid, haddr, hwdata, hwrite, prdata,
    input  hreadyout, hrdata, rvalid, herror,
    input  pselx, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_controller.sv
// APB2 sequencer of the AHB-to-APB bridge: decodes requests and runs SETUP/ACCESS on one of 3 slaves.
// Latency: pselx rises 1 cycle after accept from idle; each access is 2 cycles; read data 1 cycle after ACCESS.
// Backpressure: one transfer in flight plus one pending slot; hreadyout drops while the pending slot is full.
module apb_controller #(
  parameter int            AW   = 32,
  parameter int            DW   = 32,
  parameter logic [AW-1:0] BASE = 32'h8000_0000,
  parameter logic [AW-1:0] SPAN = 32'h0400_0000
) (
  input  logic             hclk,
  input  logic             hreset,
  apb_controller_if.slave  bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  // Upper bounds of the three slave windows, relative to BASE; two extra bits so 3*SPAN cannot wrap.
  localparam logic [AW+1:0] LIM1 = {2'b00, SPAN};
  localparam logic [AW+1:0] LIM2 = LIM1 + LIM1;
  localparam logic [AW+1:0] LIM3 = LIM2 + LIM1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          write;
    logic [2:0]    sel;
  } req_t;

  logic [1:0]    state_q, state_d;
  req_t          cur_q, cur_d;
  req_t          pend_q, pend_d;
  logic          pend_full_q, pend_full_d;
  logic [DW-1:0] hrdata_q, hrdata_d;
  logic          rvalid_q, rvalid_d;
  logic          herror_q, herror_d;

  logic [AW:0]   off_w;
  logic [AW+1:0] off_x;
  logic [2:0]    dec_sel;
  logic          mapped;
  logic          accept;
  logic          acc_map;
  logic          acc_unm;
  logic          rd_done;
  req_t          in_req;

  // The extra top bit of the subtraction is the borrow, set when haddr lies below BASE.
  assign off_w = {1'b0, bus.haddr} - {1'b0, BASE};
  assign off_x = {2'b00, off_w[AW-1:0]};

  // Address decode into a one-hot slave select; all-zero means unmapped.
  always_comb begin
    dec_sel = 3'b000;
    if (!off_w[AW]) begin
      if (off_x < LIM1)      dec_sel = 3'b001;
      else if (off_x < LIM2) dec_sel = 3'b010;
      else if (off_x < LIM3) dec_sel = 3'b100;
    end
  end

  assign mapped  = |dec_sel;
  assign accept  = bus.valid && !pend_full_q;
  assign acc_map = accept && mapped;
  assign acc_unm = accept && !mapped;
  assign in_req  = {bus.haddr, bus.hwdata, bus.hwrite, dec_sel};
  assign rd_done = (state_q == ST_ACCESS) && !cur_q.write;

  // State register; reset aborts any transfer in progress.
  always_ff @(posedge hclk) begin
    if (hreset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: ACCESS chains straight into SETUP whenever more work is queued or arriving.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (acc_map) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: state_d = (pend_full_q || acc_map) ? ST_SETUP : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request slots: cur loads on the SETUP that starts a transfer; pend only fills during SETUP.
  always_comb begin
    cur_d       = cur_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    case (state_q)
      ST_IDLE: begin
        if (acc_map) cur_d = in_req;
      end
      ST_SETUP: begin
        if (acc_map) begin
          pend_d      = in_req;
          pend_full_d = 1'b1;
        end
      end
      ST_ACCESS: begin
        // The pending request is older than anything arriving now, so it always goes first.
        if (pend_full_q) begin
          cur_d       = pend_q;
          pend_full_d = 1'b0;
        end else if (acc_map) begin
          cur_d = in_req;
        end
      end
      default: ;
    endcase
    hrdata_d = rd_done ? bus.prdata : hrdata_q;
    rvalid_d = rd_done;
    herror_d = acc_unm;
  end

  // Datapath registers and response pulses.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      cur_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      hrdata_q    <= '0;
      rvalid_q    <= 1'b0;
      herror_q    <= 1'b0;
    end else begin
      cur_q       <= cur_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      hrdata_q    <= hrdata_d;
      rvalid_q    <= rvalid_d;
      herror_q    <= herror_d;
    end
  end

  // Bus outputs: select only during SETUP/ACCESS; address/data/direction hold their last values in idle.
  always_comb begin
    bus.pselx     = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) ? cur_q.sel : 3'b000;
    bus.penable   = (state_q == ST_ACCESS);
    bus.pwrite    = cur_q.write;
    bus.paddr     = cur_q.addr;
    bus.pwdata    = cur_q.wdata;
    bus.hreadyout = !pend_full_q;
    bus.hrdata    = hrdata_q;
    bus.rvalid    = rvalid_q;
    bus.herror    = herror_q;
  end

endmodule

// File: tb/tb_apb_controller.sv
// Scoreboard bench for apb_controller: random and directed requests against a transfer-schedule model.
// Model: transfer k starts SETUP at max(accept edge, previous start + 2); the pending slot is full while a start lies ahead.
// The APB slave model returns address-derived read data; a monitor on the falling edge checks every cycle.
module tb_apb_controller;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] SPAN = 32'h0400_0000;

  logic hclk = 1'b0;
  logic hreset;

  apb_controller_if #(.AW(32), .DW(32)) bus ();

  apb_controller #(.AW(32), .DW(32), .BASE(BASE), .SPAN(SPAN)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    int          start;
    logic [2:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
  } xfer_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rd_t;

  xfer_t xq[$];
  rd_t   rq[$];
  int    eq[$];

  int checks     = 0;
  int failures   = 0;
  int edge_cnt   = 0;
  int last_start = -10;
  bit mon_en     = 1'b0;

  logic [31:0] bnd [8] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h83FF_FFFF, 32'h8400_0000,
                           32'h8BFF_FFFF, 32'h8C00_0000, 32'hFFFF_FFFF, 32'h0000_0000};

  // Read data the APB slave model returns for a given address.
  function automatic logic [31:0] slave_data(input logic [31:0] a);
    if (a == 32'h8800_0004) return 32'h0000_00C3;
    return {a[15:0], a[31:16]} ^ 32'hC3C3_0F0F;
  endfunction

  // Slave index = (addr - BASE) / SPAN; indices 0..2 map to one-hot selects, anything else is unmapped.
  function automatic logic [2:0] ref_sel(input logic [31:0] a);
    longint unsigned idx;
    if (a < BASE) return 3'b000;
    idx = longint'(a - BASE) / longint'(SPAN);
    case (idx)
      0:       return 3'b001;
      1:       return 3'b010;
      2:       return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, edge_cnt, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance one edge, and update the model for that edge.
  task automatic step(input logic rst, input logic v, input logic [31:0] a,
                      input logic [31:0] d, input logic w);
    bit          rdy_now;
    logic [2:0]  s;
    int          st;
    xfer_t       x;
    rd_t         r;
    hreset     = rst;
    bus.valid  = v;
    bus.haddr  = a;
    bus.hwdata = d;
    bus.hwrite = w;
    rdy_now = !(last_start > edge_cnt);
    @(posedge hclk);
    edge_cnt++;
    if (rst) begin
      xq.delete();
      rq.delete();
      eq.delete();
      last_start = -10;
    end else if (v && rdy_now) begin
      s = ref_sel(a);
      if (s == 3'b000) begin
        eq.push_back(edge_cnt);
      end else begin
        st = (last_start + 2 > edge_cnt) ? last_start + 2 : edge_cnt;
        last_start = st;
        x.start = st; x.sel = s; x.addr = a; x.data = d; x.wr = w;
        xq.push_back(x);
        if (!w) begin
          r.cyc  = st + 2;
          r.data = slave_data(a);
          rq.push_back(r);
        end
      end
    end
    #1;
    bus.prdata = slave_data(bus.paddr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  // Monitor: compare every cycle's outputs against the heads of the expectation queues.
  always @(negedge hclk) begin
    int   t;
    logic en_exp;
    if (mon_en) begin
      t = edge_cnt;
      check("hreadyout", bus.hreadyout, (last_start > t) ? 1'b0 : 1'b1);
      if (xq.size() > 0 && xq[0].start <= t) begin
        en_exp = (t == xq[0].start + 1);
        check("pselx", bus.pselx, xq[0].sel);
        check("penable", bus.penable, en_exp);
        check("paddr", bus.paddr, xq[0].addr);
        check("pwrite", bus.pwrite, xq[0].wr);
        if (xq[0].wr) check("pwdata", bus.pwdata, xq[0].data);
        if (en_exp) void'(xq.pop_front());
      end else begin
        check("pselx_idle", bus.pselx, 3'b000);
        check("penable_idle", bus.penable, 1'b0);
      end
      if (rq.size() > 0 && rq[0].cyc == t) begin
        check("rvalid", bus.rvalid, 1'b1);
        check("hrdata", bus.hrdata, rq[0].data);
        void'(rq.pop_front());
      end else begin
        check("rvalid_idle", bus.rvalid, 1'b0);
      end
      if (eq.size() > 0 && eq[0] == t) begin
        check("herror", bus.herror, 1'b1);
        void'(eq.pop_front());
      end else begin
        check("herror_idle", bus.herror, 1'b0);
      end
    end
  end

  initial begin
    logic [31:0] a;
    int          k;
    hreset     = 1'b1;
    bus.valid  = 1'b0;
    bus.haddr  = '0;
    bus.hwdata = '0;
    bus.hwrite = 1'b0;
    bus.prdata = '0;
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

    // Reset values
    check("rst_hreadyout", bus.hreadyout, 1'b1);
    check("rst_pselx", bus.pselx, 3'b000);
    check("rst_penable", bus.penable, 1'b0);
    check("rst_pwrite", bus.pwrite, 1'b0);
    check("rst_paddr", bus.paddr, 32'h0);
    check("rst_pwdata", bus.pwdata, 32'h0);
    check("rst_hrdata", bus.hrdata, 32'h0);
    check("rst_rvalid", bus.rvalid, 1'b0);
    check("rst_herror", bus.herror, 1'b0);
    mon_en = 1'b1;

    // Single write
    step(1'b0, 1'b1, 32'h8000_0010, 32'hA5A5_0001, 1'b1);
    idle(4);
    // Single read from slave 2
    step(1'b0, 1'b1, 32'h8800_0004, 32'h0, 1'b0);
    idle(4);
    // Back-to-back: third request is held until the pending slot drains
    step(1'b0, 1'b1, 32'h8000_0000, 32'h1111_0000, 1'b1);
    step(1'b0, 1'b1, 32'h8400_0000, 32'h2222_0000, 1'b1);
    step(1'b0, 1'b1, 32'h8000_0004, 32'h3333_0000, 1'b1);
    step(1'b0, 1'b1, 32'h8000_0004, 32'h3333_0000, 1'b1);
    idle(6);
    // Unmapped below BASE and just past the last slave
    step(1'b0, 1'b1, 32'h7FFF_FFFC, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h8C00_0000, 32'h0, 1'b0);
    idle(3);
    // Reset during ACCESS with the pending slot full
    step(1'b0, 1'b1, 32'h8000_0100, 32'hAAAA_0001, 1'b1);
    step(1'b0, 1'b1, 32'h8400_0200, 32'hBBBB_0002, 1'b1);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(5);
    // Read then pipelined write
    step(1'b0, 1'b1, 32'h8400_0008, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h8400_000C, 32'hCAFE_F00D, 1'b1);
    idle(6);

    // Random traffic with boundary addresses and occasional resets
    for (int i = 0; i < 4000; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0:       a = $urandom_range(0, 32'h7FFF_FFFF);
        1:       a = 32'h8C00_0000 + $urandom_range(0, 32'h73FF_FFFF);
        2:       a = bnd[$urandom_range(0, 7)];
        default: a = BASE + $urandom_range(0, 32'h0BFF_FFFF);
      endcase
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, a, $urandom, 1'($urandom_range(0, 1)));
    end
    idle(8);

    check("drain_xfers", xq.size(), 0);
    check("drain_reads", rq.size(), 0);
    check("drain_errors", eq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
